// File: rtl/uinst_pkg.sv
// Shared constants, word layout and state encoding for the microcode sequencer.
package uinst_pkg;

  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned DEPTH      = 310;
  localparam int unsigned CTRL_WIDTH = 40;
  localparam int unsigned CNT_WIDTH  = 8;
  localparam int unsigned OP_WIDTH   = 2;

  localparam int unsigned CTRL_LSB   = 0;
  localparam int unsigned CNT_LSB    = CTRL_LSB + CTRL_WIDTH;
  localparam int unsigned TARGET_LSB = CNT_LSB + CNT_WIDTH;
  localparam int unsigned LDCNT_BIT  = TARGET_LSB + ADDR_WIDTH;
  localparam int unsigned WAIT_BIT   = LDCNT_BIT + 1;
  localparam int unsigned OP_LSB     = WAIT_BIT + 1;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_SEQ  = 2'b00,
    OP_JMP  = 2'b01,
    OP_LOOP = 2'b10,
    OP_END  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT
  } state_e;

  typedef struct packed {
    op_e                   op;
    logic                  wt;
    logic                  ldcnt;
    logic [ADDR_WIDTH-1:0] target;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CTRL_WIDTH-1:0] ctrl;
  } uword_t;

  // Split a raw ROM word into its fields.
  function automatic uword_t decode_word(input logic [DATA_WIDTH-1:0] w);
    uword_t u;
    u.op     = op_e'(w[OP_LSB +: OP_WIDTH]);
    u.wt     = w[WAIT_BIT];
    u.ldcnt  = w[LDCNT_BIT];
    u.target = w[TARGET_LSB +: ADDR_WIDTH];
    u.cnt    = w[CNT_LSB +: CNT_WIDTH];
    u.ctrl   = w[CTRL_LSB +: CTRL_WIDTH];
    return u;
  endfunction

endpackage

// File: rtl/uinst_if.sv
// Command, ROM and datapath signals of the microcode sequencer.
interface uinst_if;
  import uinst_pkg::*;

  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_dout;
  logic                  ctrl_valid;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  dp_done;

  modport master (
    input  start, start_addr, rom_dout, dp_done,
    output busy, done, err, rom_en, rom_addr, ctrl_valid, ctrl
  );

  modport slave (
    output start, start_addr, rom_dout, dp_done,
    input  busy, done, err, rom_en, rom_addr, ctrl_valid, ctrl
  );

endinterface

// File: rtl/uinst_next_pc.sv
// Next-address and loop-counter resolution for one microinstruction.
module uinst_next_pc
  import uinst_pkg::*;
(
  input  uword_t                word,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [CNT_WIDTH-1:0]  loop_cnt,
  output logic [ADDR_WIDTH-1:0] next,
  output logic [CNT_WIDTH-1:0]  cnt_next,
  output logic                  is_end,
  output logic                  range_err
);

  localparam int unsigned NW = ADDR_WIDTH + 1;

  logic [CNT_WIDTH-1:0] eff_cnt;
  logic [NW-1:0]        next_w;
  logic                 unused_fields;

  assign unused_fields = ^{word.wt, word.ctrl};

  // One extra bit on the address keeps pc+1 overflow visible to the range check.
  always_comb begin
    eff_cnt  = word.ldcnt ? word.cnt : loop_cnt;
    cnt_next = eff_cnt;
    is_end   = 1'b0;
    next_w   = {1'b0, pc} + NW'(1);
    unique case (word.op)
      OP_SEQ:  ;
      OP_JMP:  next_w = {1'b0, word.target};
      OP_LOOP: begin
        if (eff_cnt != '0) begin
          cnt_next = eff_cnt - CNT_WIDTH'(1);
          next_w   = {1'b0, word.target};
        end
      end
      OP_END:  is_end = 1'b1;
    endcase
    next      = next_w[ADDR_WIDTH-1:0];
    range_err = !is_end && (next_w >= NW'(DEPTH));
  end

endmodule

// File: rtl/uinst_sequencer.sv
// Microcode sequencer: fetches ROM words, issues control words, resolves flow and waits.
module uinst_sequencer
  import uinst_pkg::*;
(
  input  logic    clk,
  input  logic    rstn,
  uinst_if.master bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  loop_cnt_q, loop_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [ADDR_WIDTH-1:0] held_next_q, held_next_d;
  logic                  held_end_q, held_end_d;
  logic                  held_err_q, held_err_d;

  logic                  rom_en_c;
  logic [ADDR_WIDTH-1:0] rom_addr_c;
  logic                  ctrl_valid_c;

  uword_t                word;
  logic [ADDR_WIDTH-1:0] np_next;
  logic [CNT_WIDTH-1:0]  np_cnt;
  logic                  np_end;
  logic                  np_err;

  assign word = decode_word(bus.rom_dout);

  uinst_next_pc u_next_pc (
    .word      (word),
    .pc        (pc_q),
    .loop_cnt  (loop_cnt_q),
    .next      (np_next),
    .cnt_next  (np_cnt),
    .is_end    (np_end),
    .range_err (np_err)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      loop_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ctrl_q      <= '0;
      held_next_q <= '0;
      held_end_q  <= 1'b0;
      held_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      loop_cnt_q  <= loop_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ctrl_q      <= ctrl_d;
      held_next_q <= held_next_d;
      held_end_q  <= held_end_d;
      held_err_q  <= held_err_d;
    end
  end

  // A WAIT word latches its resolved flow at issue so the counter is never applied twice.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    loop_cnt_d   = loop_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    ctrl_d       = ctrl_q;
    held_next_d  = held_next_q;
    held_end_d   = held_end_q;
    held_err_d   = held_err_q;
    rom_en_c     = 1'b0;
    rom_addr_c   = pc_q;
    ctrl_valid_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.start_addr < ADDR_WIDTH'(DEPTH)) begin
            pc_d    = bus.start_addr;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_FETCH;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end

      S_FETCH: begin
        rom_en_c   = 1'b1;
        rom_addr_c = pc_q;
        state_d    = S_EXEC;
      end

      S_EXEC: begin
        ctrl_valid_c = 1'b1;
        ctrl_d       = word.ctrl;
        loop_cnt_d   = np_cnt;
        if (word.wt) begin
          held_next_d = np_next;
          held_end_d  = np_end;
          held_err_d  = np_err;
          state_d     = S_WAIT;
        end else if (np_end || np_err) begin
          err_d   = err_q | np_err;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          rom_en_c   = 1'b1;
          rom_addr_c = np_next;
          pc_d       = np_next;
        end
      end

      S_WAIT: begin
        if (bus.dp_done) begin
          if (held_end_q || held_err_q) begin
            err_d   = err_q | held_err_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            rom_en_c   = 1'b1;
            rom_addr_c = held_next_q;
            pc_d       = held_next_q;
            state_d    = S_EXEC;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rom_en     = rom_en_c;
  assign bus.rom_addr   = rom_addr_c;
  assign bus.ctrl_valid = ctrl_valid_c;
  assign bus.ctrl       = ctrl_valid_c ? word.ctrl : ctrl_q;

endmodule

// File: tb/tb_uinst_sequencer.sv
// Directed bench for uinst_sequencer with a behavioural synchronous ROM.
module tb_uinst_sequencer;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [63:0] mem [0:4095];
  logic [39:0] loop_exp [0:9] = '{40'h50, 40'h60, 40'h70, 40'h60, 40'h70,
                                  40'h60, 40'h70, 40'h60, 40'h70, 40'h80};

  uinst_if bus ();

  uinst_sequencer dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // 1-cycle read latency, output held while not enabled
  always @(posedge clk or negedge rstn) begin
    if (!rstn) bus.rom_dout <= '0;
    else if (bus.rom_en) bus.rom_dout <= mem[bus.rom_addr];
  end

  function automatic logic [63:0] mk(input logic [1:0] op, input logic wt, input logic ld,
                                     input logic [11:0] tgt, input logic [7:0] cnt,
                                     input logic [39:0] c);
    return {op, wt, ld, tgt, cnt, c};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_basic;
    mem[0] = mk(2'b00, 1'b0, 1'b0, 12'd0, 8'd0, 40'h1);
    mem[1] = mk(2'b00, 1'b0, 1'b0, 12'd0, 8'd0, 40'h2);
    mem[2] = mk(2'b11, 1'b0, 1'b0, 12'd0, 8'd0, 40'h3);
  endtask

  task automatic run_basic(input string tag);
    bus.start = 1'b1; bus.start_addr = 12'd0;
    tick; bus.start = 1'b0;
    chk({tag, "_fetch_busy"}, 64'(bus.busy), 64'd1);
    chk({tag, "_fetch_rom_en"}, 64'(bus.rom_en), 64'd1);
    chk({tag, "_fetch_rom_addr"}, 64'(bus.rom_addr), 64'd0);
    chk({tag, "_fetch_valid"}, 64'(bus.ctrl_valid), 64'd0);
    tick;
    chk({tag, "_issue0_valid"}, 64'(bus.ctrl_valid), 64'd1);
    chk({tag, "_issue0_ctrl"}, 64'(bus.ctrl), 64'h1);
    tick;
    chk({tag, "_issue1_ctrl"}, 64'(bus.ctrl), 64'h2);
    tick;
    chk({tag, "_issue2_ctrl"}, 64'(bus.ctrl), 64'h3);
    chk({tag, "_end_rom_en"}, 64'(bus.rom_en), 64'd0);
    chk({tag, "_end_busy"}, 64'(bus.busy), 64'd1);
    chk({tag, "_end_done"}, 64'(bus.done), 64'd0);
    tick;
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
    chk({tag, "_idle_valid"}, 64'(bus.ctrl_valid), 64'd0);
    chk({tag, "_ctrl_held"}, 64'(bus.ctrl), 64'h3);
    tick;
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.start_addr = '0; bus.dp_done = 1'b0;

    // Reset state
    tick; tick;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_rom_en", 64'(bus.rom_en), 64'd0);
    chk("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
    chk("rst_valid", 64'(bus.ctrl_valid), 64'd0);
    chk("rst_ctrl", 64'(bus.ctrl), 64'd0);
    rstn = 1'b1;
    tick;

    // Straight-line SEQ, SEQ, END
    load_basic();
    run_basic("seq");

    // Counted loop, with a start pulse ignored mid-run
    mem[5] = mk(2'b00, 1'b0, 1'b1, 12'd0, 8'd3, 40'h50);
    mem[6] = mk(2'b00, 1'b0, 1'b0, 12'd0, 8'd0, 40'h60);
    mem[7] = mk(2'b10, 1'b0, 1'b0, 12'd6, 8'd0, 40'h70);
    mem[8] = mk(2'b11, 1'b0, 1'b0, 12'd0, 8'd0, 40'h80);
    bus.start = 1'b1; bus.start_addr = 12'd5;
    tick; bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      bus.start = (i == 3);
      bus.start_addr = 12'd0;
      chk($sformatf("loop_valid%0d", i), 64'(bus.ctrl_valid), 64'd1);
      chk($sformatf("loop_ctrl%0d", i), 64'(bus.ctrl), 64'(loop_exp[i]));
    end
    bus.start = 1'b0;
    tick;
    chk("loop_done", 64'(bus.done), 64'd1);
    chk("loop_err", 64'(bus.err), 64'd0);
    chk("loop_cnt_final", 64'(dut.loop_cnt_q), 64'd0);
    tick;

    // WAIT word: dp_done during the issue cycle is ignored
    mem[0] = mk(2'b00, 1'b1, 1'b0, 12'd0, 8'd0, 40'hA);
    mem[1] = mk(2'b11, 1'b0, 1'b0, 12'd0, 8'd0, 40'hB);
    bus.start = 1'b1; bus.start_addr = 12'd0;
    tick; bus.start = 1'b0;
    tick;
    bus.dp_done = 1'b1;
    chk("wait_issue_ctrl", 64'(bus.ctrl), 64'hA);
    chk("wait_issue_rom_en", 64'(bus.rom_en), 64'd0);
    tick;
    bus.dp_done = 1'b0;
    #1;
    chk("wait_w0_valid", 64'(bus.ctrl_valid), 64'd0);
    chk("wait_w0_rom_en", 64'(bus.rom_en), 64'd0);
    for (int i = 1; i < 4; i++) begin
      tick;
      chk($sformatf("wait_w%0d_valid", i), 64'(bus.ctrl_valid), 64'd0);
      chk($sformatf("wait_w%0d_busy", i), 64'(bus.busy), 64'd1);
    end
    tick;
    bus.dp_done = 1'b1;
    #1;
    chk("wait_release_rom_en", 64'(bus.rom_en), 64'd1);
    chk("wait_release_rom_addr", 64'(bus.rom_addr), 64'd1);
    chk("wait_release_valid", 64'(bus.ctrl_valid), 64'd0);
    tick;
    bus.dp_done = 1'b0;
    chk("wait_next_valid", 64'(bus.ctrl_valid), 64'd1);
    chk("wait_next_ctrl", 64'(bus.ctrl), 64'hB);
    tick;
    chk("wait_done", 64'(bus.done), 64'd1);
    tick;

    // Out-of-range start address
    bus.start = 1'b1; bus.start_addr = 12'd310;
    #1;
    chk("badstart_rom_en", 64'(bus.rom_en), 64'd0);
    tick; bus.start = 1'b0;
    chk("badstart_err", 64'(bus.err), 64'd1);
    chk("badstart_done", 64'(bus.done), 64'd1);
    chk("badstart_busy", 64'(bus.busy), 64'd0);
    chk("badstart_rom_en2", 64'(bus.rom_en), 64'd0);
    tick;
    chk("badstart_done_pulse", 64'(bus.done), 64'd0);
    chk("badstart_err_sticky", 64'(bus.err), 64'd1);

    // pc+1 running off the end of the ROM
    mem[309] = mk(2'b00, 1'b0, 1'b0, 12'd0, 8'd0, 40'h309);
    bus.start = 1'b1; bus.start_addr = 12'd309;
    tick; bus.start = 1'b0;
    chk("edge_err_cleared", 64'(bus.err), 64'd0);
    tick;
    chk("edge_ctrl", 64'(bus.ctrl), 64'h309);
    chk("edge_rom_en", 64'(bus.rom_en), 64'd0);
    tick;
    chk("edge_err", 64'(bus.err), 64'd1);
    chk("edge_done", 64'(bus.done), 64'd1);
    chk("edge_busy", 64'(bus.busy), 64'd0);
    tick;
    bus.start = 1'b1; bus.start_addr = 12'd1;
    tick; bus.start = 1'b0;
    chk("restart_err_cleared", 64'(bus.err), 64'd0);
    tick;
    chk("restart_ctrl", 64'(bus.ctrl), 64'hB);
    tick;
    chk("restart_done", 64'(bus.done), 64'd1);
    chk("restart_err", 64'(bus.err), 64'd0);
    tick;

    // Reset in the middle of a loop, then a clean run
    load_basic();
    bus.start = 1'b1; bus.start_addr = 12'd5;
    tick; bus.start = 1'b0;
    tick; tick; tick;
    chk("midrst_pre_ctrl", 64'(bus.ctrl), 64'h70);
    rstn = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_valid", 64'(bus.ctrl_valid), 64'd0);
    chk("midrst_rom_en", 64'(bus.rom_en), 64'd0);
    chk("midrst_rom_addr", 64'(bus.rom_addr), 64'd0);
    chk("midrst_ctrl", 64'(bus.ctrl), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    tick;
    chk("midrst_done_after", 64'(bus.done), 64'd0);
    rstn = 1'b1;
    tick;
    run_basic("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
